// File: rtl/pipelined_alu_core_if.sv
// Issue and result handshake bundle for pipelined_alu_core.
// The slave modport is the core side; the master modport is the driver/consumer side.
interface pipelined_alu_core_if #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3
);
  localparam int INSTR_W = 3 + 3 * RA_W;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [RA_W-1:0]    out_rd;
  logic               out_zero;
  logic               out_carry;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_zero, out_carry
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_zero, out_carry
  );
endinterface

// File: rtl/pipelined_alu_core.sv
// Two-stage in-order ALU core: ID register -> combinational RF read + ALU -> OUT register.
// The register file is written on the same edge the OUT register loads, so a dependent
// instruction accepted on that edge reads the new value without forwarding.
module pipelined_alu_core #(
  parameter  int DATA_W  = 8,
  parameter  int NREG    = 8,
  parameter  int ZERO_R0 = 0,
  parameter  int CNT_W   = 16,
  localparam int RA_W    = $clog2(NREG),
  localparam int INSTR_W = 3 + 3 * RA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  pipelined_alu_core_if.slave  bus,
  input  logic [RA_W-1:0]      dbg_addr,
  output logic [DATA_W-1:0]    dbg_data,
  output logic [CNT_W-1:0]     retire_cnt
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_LDI = 3'b111
  } op_e;

  logic [DATA_W-1:0]  rf [NREG];
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  op_e                id_op;
  logic [RA_W-1:0]    id_ra, id_rb, id_rd;
  logic [DATA_W-1:0]  op_a, op_b;
  logic [DATA_W:0]    wide;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_carry, alu_zero;
  logic               advance, accept;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [RA_W-1:0]    out_rd_q;
  logic               out_zero_q, out_carry_q;
  logic [CNT_W-1:0]   retire_q;
  logic               rd_writable;

  // Instruction field decode of the ID register
  always_comb begin
    id_op = op_e'(id_instr[INSTR_W-1 -: 3]);
    id_ra = id_instr[3*RA_W-1 -: RA_W];
    id_rb = id_instr[2*RA_W-1 -: RA_W];
    id_rd = id_instr[RA_W-1:0];
  end

  // Operand and debug reads; r0 is masked to zero when hard-wired
  always_comb begin
    op_a     = rf[id_ra];
    op_b     = rf[id_rb];
    dbg_data = rf[dbg_addr];
    if (ZERO_R0 != 0) begin
      if (id_ra == '0)    op_a     = '0;
      if (id_rb == '0)    op_b     = '0;
      if (dbg_addr == '0) dbg_data = '0;
    end
  end

  // ALU: result and per-result flags
  always_comb begin
    wide       = '0;
    alu_result = '0;
    alu_carry  = 1'b0;
    unique case (id_op)
      OP_ADD: begin
        wide       = {1'b0, op_a} + {1'b0, op_b};
        alu_result = wide[DATA_W-1:0];
        alu_carry  = wide[DATA_W];
      end
      OP_SUB: begin
        // the extra MSB of the widened difference is the borrow (A < B)
        wide       = {1'b0, op_a} - {1'b0, op_b};
        alu_result = wide[DATA_W-1:0];
        alu_carry  = wide[DATA_W];
      end
      OP_AND: alu_result = op_a & op_b;
      OP_OR:  alu_result = op_a | op_b;
      OP_XOR: alu_result = op_a ^ op_b;
      OP_SHL: begin
        alu_result = {op_a[DATA_W-2:0], 1'b0};
        alu_carry  = op_a[DATA_W-1];
      end
      OP_SHR: begin
        alu_result = {1'b0, op_a[DATA_W-1:1]};
        alu_carry  = op_a[0];
      end
      OP_LDI: alu_result = DATA_W'({id_ra, id_rb});
      default: ;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Pipeline handshake
  always_comb begin
    advance      = id_valid && (!out_valid_q || bus.out_ready);
    bus.in_ready = !id_valid || advance;
    accept       = bus.in_valid && bus.in_ready;
    rd_writable  = !((ZERO_R0 != 0) && (id_rd == '0));
  end

  // ID stage register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= '0;
    end else if (accept) begin
      id_valid <= 1'b1;
      id_instr <= bus.in_instr;
    end else if (advance) begin
      id_valid <= 1'b0;
    end
  end

  // OUT stage register, held while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_zero_q  <= 1'b0;
      out_carry_q <= 1'b0;
    end else if (advance) begin
      out_valid_q <= 1'b1;
      out_data_q  <= alu_result;
      out_rd_q    <= id_rd;
      out_zero_q  <= alu_zero;
      out_carry_q <= alu_carry;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Register file write-back on advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf <= '{default: '0};
    end else if (advance && rd_writable) begin
      rf[id_rd] <= alu_result;
    end
  end

  // Retire counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_q <= '0;
    end else if (advance) begin
      retire_q <= retire_q + CNT_W'(1);
    end
  end

  // Output port mapping
  always_comb begin
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    bus.out_rd    = out_rd_q;
    bus.out_zero  = out_zero_q;
    bus.out_carry = out_carry_q;
    retire_cnt    = retire_q;
  end

endmodule

// File: tb/tb_pipelined_alu_core.sv
// Scoreboard bench for pipelined_alu_core: stimulus pushes hand-computed results,
// a monitor pops and compares on every accepted output.
module tb_pipelined_alu_core;
  localparam int DATA_W = 8;
  localparam int NREG   = 8;
  localparam int CNT_W  = 4;
  localparam int RA_W   = 3;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, LDI = 3'd7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_alu_core_if #(.DATA_W(DATA_W), .RA_W(RA_W)) bus ();
  pipelined_alu_core_if #(.DATA_W(DATA_W), .RA_W(RA_W)) zbus ();

  logic [RA_W-1:0]   dbg_addr, zdbg_addr;
  logic [DATA_W-1:0] dbg_data, zdbg_data;
  logic [CNT_W-1:0]  retire_cnt, zretire_cnt;

  pipelined_alu_core #(.DATA_W(DATA_W), .NREG(NREG), .ZERO_R0(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .retire_cnt(retire_cnt)
  );

  pipelined_alu_core #(.DATA_W(DATA_W), .NREG(NREG), .ZERO_R0(1), .CNT_W(CNT_W)) dut_z (
    .clk(clk), .reset(reset), .bus(zbus),
    .dbg_addr(zdbg_addr), .dbg_data(zdbg_data), .retire_cnt(zretire_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [RA_W-1:0]   rd;
    logic              zero;
    logic              carry;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic t4_done;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] mk(input logic [2:0] op, input logic [2:0] ra,
                                     input logic [2:0] rb, input logic [2:0] rd);
    return {op, ra, rb, rd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one instruction and hold it until accepted; push its expected result on acceptance
  task automatic issue(input logic [11:0] ins, input logic [7:0] d, input logic [2:0] rd,
                       input logic z, input logic c);
    logic r;
    int   n;
    exp_t e;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    forever begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: instr %0h never accepted", ins);
        return;
      end
    end
    e.data = d; e.rd = rd; e.zero = z; e.carry = c;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic dbg_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(name, dbg_data, exp);
  endtask

  // Monitor: a result is consumed when out_valid && out_ready at the following edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: data %0h rd %0d, no result expected",
                 bus.out_data, bus.out_rd);
      end else begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_rd", bus.out_rd, e.rd);
        chk("out_zero", bus.out_zero, e.zero);
        chk("out_carry", bus.out_carry, e.carry);
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b1;
    zbus.in_valid = 1'b0; zbus.in_instr = '0; zbus.out_ready = 1'b1;
    dbg_addr = '0; zdbg_addr = '0;
    t4_done = 1'b0;

    // 1: reset state
    #2;
    chk("t1_out_valid", bus.out_valid, 0);
    chk("t1_in_ready", bus.in_ready, 1);
    chk("t1_retire", retire_cnt, 0);
    chk("t1_out_data", bus.out_data, 0);
    for (int a = 0; a < 8; a++) dbg_chk($sformatf("t1_dbg%0d", a), 3'(a), 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 2: back-to-back LDI, LDI, dependent ADD
    pop_cyc.delete();
    issue(mk(LDI, 3'd0, 3'd5, 3'd1), 8'h05, 3'd1, 1'b0, 1'b0);
    issue(mk(LDI, 3'd0, 3'd3, 3'd2), 8'h03, 3'd2, 1'b0, 1'b0);
    issue(mk(ADD, 3'd1, 3'd2, 3'd3), 8'h08, 3'd3, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    drain();
    chk("t2_consecutive", (pop_cyc.size() == 3) ? pop_cyc[2] - pop_cyc[0] : -1, 2);

    // 3: subtraction borrow, zero flag, add carry-out, AND
    issue(mk(SUB, 3'd2, 3'd1, 3'd4), 8'hFE, 3'd4, 1'b0, 1'b1);
    issue(mk(SUB, 3'd1, 3'd1, 3'd5), 8'h00, 3'd5, 1'b1, 1'b0);
    issue(mk(LDI, 3'd0, 3'd1, 3'd7), 8'h01, 3'd7, 1'b0, 1'b0);
    issue(mk(SUB, 3'd0, 3'd7, 3'd6), 8'hFF, 3'd6, 1'b0, 1'b1);
    issue(mk(ADD, 3'd6, 3'd7, 3'd6), 8'h00, 3'd6, 1'b1, 1'b1);
    issue(mk(AND_, 3'd4, 3'd3, 3'd5), 8'h08, 3'd5, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    drain();
    chk("t3_retire", retire_cnt, 9);

    // 4: backpressure with three instructions offered
    bus.out_ready = 1'b0;
    fork
      begin
        issue(mk(OR_, 3'd1, 3'd2, 3'd1), 8'h07, 3'd1, 1'b0, 1'b0);
        issue(mk(XOR_, 3'd1, 3'd4, 3'd2), 8'hF9, 3'd2, 1'b0, 1'b0);
        issue(mk(ADD, 3'd2, 3'd7, 3'd3), 8'hFA, 3'd3, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        t4_done = 1'b1;
      end
    join_none
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_in_ready_stall", bus.in_ready, 0);
      chk("t4_out_valid_hold", bus.out_valid, 1);
      chk("t4_out_data_hold", bus.out_data, 8'h07);
      chk("t4_retire_hold", retire_cnt, 10);
    end
    dbg_chk("t4_r1_written", 3'd1, 8'h07);
    dbg_chk("t4_r2_unchanged", 3'd2, 8'h03);
    dbg_chk("t4_r3_unchanged", 3'd3, 8'h08);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && !t4_done; i++) begin
      @(posedge clk); #1;
    end
    chk("t4_issue_done", t4_done, 1);
    drain();
    chk("t4_retire", retire_cnt, 12);
    dbg_chk("t4_r1", 3'd1, 8'h07);
    dbg_chk("t4_r2", 3'd2, 8'hF9);
    dbg_chk("t4_r3", 3'd3, 8'hFA);

    // 5: shifts and retire counter wrap
    @(posedge clk); #1;
    issue(mk(LDI, 3'd4, 3'd0, 3'd1), 8'h20, 3'd1, 1'b0, 1'b0);
    issue(mk(SHL, 3'd1, 3'd0, 3'd1), 8'h40, 3'd1, 1'b0, 1'b0);
    issue(mk(SHL, 3'd1, 3'd0, 3'd1), 8'h80, 3'd1, 1'b0, 1'b0);
    issue(mk(SHL, 3'd1, 3'd0, 3'd1), 8'h00, 3'd1, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    drain();
    chk("t5_retire_wrap", retire_cnt, 0);
    issue(mk(SHR, 3'd7, 3'd0, 3'd2), 8'h00, 3'd2, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    drain();
    chk("t5_retire_after_wrap", retire_cnt, 1);

    // 6: asynchronous reset with ID and OUT both full
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    fork
      begin
        issue(mk(ADD, 3'd7, 3'd7, 3'd4), 8'h02, 3'd4, 1'b0, 1'b0);
        issue(mk(ADD, 3'd7, 3'd7, 3'd5), 8'h02, 3'd5, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("t6_pre_out_valid", bus.out_valid, 1);
    chk("t6_pre_in_ready", bus.in_ready, 0);
    #1 reset = 1'b1;
    #1;
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    chk("t6_retire", retire_cnt, 0);
    chk("t6_out_data", bus.out_data, 0);
    for (int a = 0; a < 8; a++) dbg_chk($sformatf("t6_dbg%0d", a), 3'(a), 8'h00);
    disable fork;
    sb.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;

    // 6b: hard-zero r0 instance
    zbus.in_valid = 1'b1;
    zbus.in_instr = mk(LDI, 3'd0, 3'd7, 3'd0);
    @(posedge clk);
    #1 zbus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("z_out_valid", zbus.out_valid, 1);
    chk("z_out_data", zbus.out_data, 8'h07);
    chk("z_out_rd", zbus.out_rd, 0);
    zdbg_addr = 3'd0;
    #1;
    chk("z_dbg_r0", zdbg_data, 8'h00);
    @(posedge clk);
    #1;
    zbus.in_valid = 1'b1;
    zbus.in_instr = mk(ADD, 3'd0, 3'd0, 3'd1);
    @(posedge clk);
    #1 zbus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("z_add_r0_data", zbus.out_data, 8'h00);
    chk("z_add_r0_zero", zbus.out_zero, 1);
    chk("z_retire", zretire_cnt, 2);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
